// File: rtl/cmd_frame_builder.sv
// rtl/cmd_frame_builder.sv - SD command frame builder with bit-serial CRC7
// Captures cmd_index/argument, runs CRC7 one bit per clock, holds the 48-bit frame under valid/ack.
module cmd_frame_builder (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] argument,
  output logic [47:0] frame,
  output logic        frame_valid,
  input  logic        frame_ack,
  output logic        busy,
  output logic [6:0]  crc7
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_VALID = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [39:0] r_shift;
  logic [5:0]  r_cnt;
  logic [6:0]  r_crc;
  logic [47:0] r_frame;

  logic        w_fb;
  logic [6:0]  w_crc_next;
  logic [39:0] w_shift_next;

  assign w_fb         = r_crc[6] ^ r_shift[39];
  assign w_crc_next   = {r_crc[5:3], r_crc[2] ^ w_fb, r_crc[1:0], w_fb};
  // Rotating keeps the captured bits intact: after 40 rotations the register is back to the original.
  assign w_shift_next = {r_shift[38:0], r_shift[39]};

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_CALC;
      S_CALC:  if (r_cnt == 6'd0) w_next_state = S_VALID;
      S_VALID: if (frame_ack) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_crc   <= '0;
      r_frame <= {48{1'b1}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shift <= {2'b01, cmd_index, argument};
            r_crc   <= '0;
            r_cnt   <= 6'd39;
          end
        end
        S_CALC: begin
          r_shift <= w_shift_next;
          r_crc   <= w_crc_next;
          r_cnt   <= r_cnt - 6'd1;
          if (r_cnt == 6'd0) r_frame <= {w_shift_next, w_crc_next, 1'b1};
        end
        default: ;
      endcase
    end
  end

  assign frame       = r_frame;
  assign frame_valid = (r_state == S_VALID);
  assign busy        = (r_state != S_IDLE);
  assign crc7        = r_crc;

endmodule

// File: tb/tb_cmd_frame_builder.sv
// tb/tb_cmd_frame_builder.sv - randomized self-checking bench for cmd_frame_builder
module tb_cmd_frame_builder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  cmd_index = '0;
  logic [31:0] argument = '0;
  logic        frame_ack = 1'b0;
  logic [47:0] frame;
  logic        frame_valid;
  logic        busy;
  logic [6:0]  crc7;

  int n_checks = 0;
  int n_errors = 0;

  cmd_frame_builder dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .cmd_index   (cmd_index),
    .argument    (argument),
    .frame       (frame),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
    .busy        (busy),
    .crc7        (crc7)
  );

  always #5 clk = ~clk;

  // Minimal serializer: load on ack, then shift MSB first with idle-high fill.
  logic [47:0] ser_sr = {48{1'b1}};
  always @(posedge clk) begin
    if (frame_ack) ser_sr <= frame;
    else           ser_sr <= {ser_sr[46:0], 1'b1};
  end

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Polynomial long division of message * x^7 by x^7 + x^3 + 1.
  function automatic logic [47:0] ref_frame(input logic [5:0] c, input logic [31:0] a);
    logic [46:0] v;
    v = {2'b01, c, a, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (v[i]) v = v ^ (47'(8'h89) << (i - 7));
    return {2'b01, c, a, v[6:0], 1'b1};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic build(input logic [5:0] c, input logic [31:0] a, input int hold,
                       input bit noise, input bit start_at_ack, input string tag);
    logic [47:0] exp_f;
    int          n;
    bit          stable_ok;
    exp_f     = ref_frame(c, a);
    cmd_index = c;
    argument  = a;
    start     = 1'b1;
    tick;
    start = 1'b0;
    chk({tag, "/busy_e0"}, {47'd0, busy}, 48'd1);
    n = 0;
    while (!frame_valid && n < 100) begin
      if (noise) begin
        start     = 1'($urandom);
        cmd_index = 6'($urandom);
        argument  = $urandom;
      end
      tick;
      n++;
    end
    chk({tag, "/latency"}, 48'(n), 48'd40);
    chk({tag, "/frame"}, frame, exp_f);
    chk({tag, "/crc7"}, {41'd0, crc7}, {41'd0, exp_f[7:1]});
    stable_ok = 1'b1;
    for (int k = 0; k < hold; k++) begin
      if (noise) begin
        start     = 1'($urandom);
        cmd_index = 6'($urandom);
        argument  = $urandom;
      end
      tick;
      if (frame !== exp_f || frame_valid !== 1'b1 || busy !== 1'b1) stable_ok = 1'b0;
    end
    if (hold > 0) chk({tag, "/hold_stable"}, {47'd0, stable_ok}, 48'd1);
    start     = start_at_ack;
    frame_ack = 1'b1;
    tick;
    frame_ack = 1'b0;
    start     = 1'b0;
    chk({tag, "/valid_after_ack"}, {47'd0, frame_valid}, 48'd0);
    chk({tag, "/busy_after_ack"}, {47'd0, busy}, 48'd0);
    chk({tag, "/frame_retained"}, frame, exp_f);
  endtask

  initial begin
    logic [47:0] got;

    repeat (3) tick;
    chk("reset/frame", frame, {48{1'b1}});
    chk("reset/valid", {47'd0, frame_valid}, 48'd0);
    chk("reset/busy", {47'd0, busy}, 48'd0);
    chk("reset/crc7", {41'd0, crc7}, 48'd0);
    reset = 1'b0;
    tick;

    chk("ref/cmd0", ref_frame(6'd0, 32'd0), 48'h40_0000_0000_95);
    build(6'd0, 32'd0, 0, 1'b0, 1'b0, "cmd0");
    for (int i = 0; i < 48; i++) begin
      got[47 - i] = ser_sr[47];
      tick;
    end
    chk("serial/cmd0", got, 48'h40_0000_0000_95);

    build(6'd8, 32'h0000_01AA, 0, 1'b0, 1'b0, "cmd8");
    chk("cmd8/const", frame, 48'h48_0000_01AA_87);
    build(6'd55, 32'd0, 0, 1'b0, 1'b0, "cmd55");
    chk("cmd55/const", frame, 48'h77_0000_0000_65);

    build(6'd17, 32'd0, 20, 1'b1, 1'b0, "cmd17");
    chk("cmd17/const", frame, 48'h51_0000_0000_55);
    tick;
    chk("cmd17/no_second_build", {47'd0, busy}, 48'd0);

    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (20) tick;
    chk("rst_calc/busy_before", {47'd0, busy}, 48'd1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("rst_calc/valid", {47'd0, frame_valid}, 48'd0);
    chk("rst_calc/busy", {47'd0, busy}, 48'd0);
    chk("rst_calc/frame", frame, {48{1'b1}});
    build(6'd0, 32'd0, 0, 1'b0, 1'b0, "cmd0_after_rst");
    chk("cmd0_after_rst/const", frame, 48'h40_0000_0000_95);

    build(6'd9, 32'h1234_5678, 2, 1'b0, 1'b1, "start_ack");
    tick;
    chk("start_ack/no_build", {47'd0, busy}, 48'd0);

    frame_ack = 1'b1;
    tick;
    tick;
    frame_ack = 1'b0;
    chk("idle_ack/busy", {47'd0, busy}, 48'd0);
    chk("idle_ack/valid", {47'd0, frame_valid}, 48'd0);

    for (int r = 0; r < 15; r++) begin
      build(6'($urandom), $urandom, int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), "rand");
      if ($urandom_range(0, 1) == 1) tick;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/cmd_frame_builder.md
# cmd_frame_builder

Upstream stage of the SD host command serializer. It accepts a command index and a 32-bit argument, computes the CRC7 bit-serially, and presents a complete 48-bit SD command frame to the serializer. The frame is held under a valid/ack handshake. The block owns frame formatting only; bit-level transmission stays in the serializer.

## Interface
Parameters: none. Frame width (48), CRC width (7) and polynomial are fixed by the SD physical layer.

- clk  input  1  single clock; all state changes on rising edge
- reset  input  1  synchronous, active-high; clears all state on the next rising edge
- start  input  1  request to build a frame from cmd_index/argument; sampled only in IDLE
- cmd_index  input  6  command number (e.g. 0, 8, 17, 55); captured on the accepting edge
- argument  input  32  command argument; captured on the accepting edge
- frame  output  48  assembled frame, MSB transmitted first; connects to serializer `in`
- frame_valid  output  1  frame is complete and stable
- frame_ack  input  1  consumer has latched the frame; honoured only while frame_valid=1
- busy  output  1  high in CALC and VALID; start is ignored while high
- crc7  output  7  CRC register (debug); final value equals frame[7:1] while valid

## Operation
- Frame layout: bit47 = 0 (start), bit46 = 1 (host transmission), [45:40] = cmd_index, [39:8] = argument, [7:1] = CRC7, bit0 = 1 (end).
- CRC7:
  - Polynomial x^7 + x^3 + 1, initial value 0.
  - Computed over the 40 bits 47..8, MSB first, one bit per clock.
  - Per bit d: fb = crc[6] ^ d; crc_next = {crc[5:3], crc[2]^fb, crc[1:0], fb}.
- State machine:
  - IDLE: busy=0, frame_valid=0. If start=1, capture {2'b01, cmd_index, argument} into a 40-bit shift register, clear crc to 0, load bit counter to 39, go to CALC.
  - CALC: busy=1. Each edge shifts the MSB of the shift register into the CRC and decrements the counter. On the edge that processes the bit with counter=0, register frame = {captured 40 bits, crc_next, 1'b1} and go to VALID.
  - VALID: busy=1, frame_valid=1, frame stable. On an edge with frame_ack=1, go to IDLE.
- Held and ignored inputs:
  - frame retains its last value after ack until the next frame is registered.
  - cmd_index/argument changes after capture have no effect on the frame in flight.
  - start while busy=1 is dropped; it is not queued.
  - frame_ack outside VALID is ignored.
- Simultaneous start and frame_ack in VALID: ack is taken, start is dropped. Requester must reassert start once busy=0.

## Timing
- Reset values: frame = 48'hFFFF_FFFF_FFFF (idle-high line), frame_valid = 0, busy = 0, crc7 = 0, state = IDLE.
- Reset asserted in any state returns to IDLE on the next edge. An in-flight frame is discarded and frame_valid falls on that edge.
- Let E0 be the edge that samples start=1 in IDLE:
  - busy=1 from E0.
  - Edges E1..E40 process the 40 bits.
  - frame and frame_valid=1 are updated at E40 (40-cycle latency).
- frame_ack=1 sampled at edge Ek in VALID: frame_valid=0 and busy=0 after Ek. A new start can be sampled at Ek+1.
- Minimum frame-to-frame period is 42 cycles: E0, E1..E40, one ack edge, return to IDLE, next start.
- No combinational path from inputs to outputs; all outputs are registered.

## Test plan
- CMD0, argument 0, start pulse, ack one cycle after valid: frame = 48'h40_0000_0000_95; frame_valid rises exactly 40 edges after E0; crc7 = 7'h4A.
- CMD8 with argument 32'h0000_01AA, then CMD55 with argument 0, back-to-back (start reasserted when busy=0): frames 48'h48_0000_01AA_87 and 48'h77_0000_0000_65.
- CMD17, argument 0, ack withheld 20 cycles: frame = 48'h51_0000_0000_55 held stable with valid=1 throughout. start pulses and cmd_index/argument changes during CALC and VALID do not alter the frame or start a second build.
- Reset asserted at cycle 20 of CALC: after the next edge, frame_valid=0, busy=0, frame=48'hFFFF_FFFF_FFFF. A following CMD0 build produces the correct 48'h40_0000_0000_95.
- start and frame_ack high together in VALID: return to IDLE, no new build (busy stays 0). frame_ack pulsed in IDLE has no effect.
- Integration with the serializer: frame drives serializer `in`, frame_ack strobes the serializer's load/reset. The serial output of CMD0 matches bits 47..0 of 48'h40_0000_0000_95 in order.
